// File: rtl/wavelet_pkg.sv
// Shared types and width helpers for the Haar lifting stages.
// Optional feature macro used by the stages: HAAR_DEADZONE_EN.
package wavelet_pkg;

    // Position of the next accepted sample within its even/odd pair
    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    // Index width for n items, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Detail coefficient width: one bit wider than the samples so odd-even never overflows
    function automatic int unsigned detail_w(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/haar_lift_core.sv
// Combinational integer Haar lifting butterfly: (even, odd) -> (a, d).
// The dead-zone compare is always built; a zero threshold never zeroes d.
module haar_lift_core
    import wavelet_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] even,
    input  logic signed [W-1:0] odd,
    input  logic        [W-1:0] thresh,
    output logic signed [W-1:0] a,
    output logic signed [W:0]   d
);

    localparam int unsigned DW = detail_w(W);

    logic signed [DW-1:0] even_x;
    logic signed [DW-1:0] odd_x;
    logic signed [DW-1:0] d_raw;
    logic signed [DW-1:0] a_full;
    logic        [DW-1:0] d_abs;

    // Predict/update in W+1 bits; a is the floor of the pair mean so it always fits in W
    always_comb begin
        even_x = {even[W-1], even};
        odd_x  = {odd[W-1], odd};
        d_raw  = odd_x - even_x;
        a_full = even_x + (d_raw >>> 1);
        a      = a_full[W-1:0];
        d_abs  = d_raw[DW-1] ? DW'(-d_raw) : DW'(d_raw);
        if (d_abs < {1'b0, thresh}) begin
            d = '0;
        end else begin
            d = d_raw;
        end
    end

endmodule

// File: rtl/haar_lift_stage.sv
// Streaming one-level Haar lifting stage with CH round-robin interleaved channels.
// Even samples are parked per channel; each odd sample emits one (a, d) pair
// through a single output register with valid/ready handshake.
// Optional: define HAAR_DEADZONE_EN to add the thresh port (detail dead-zone).
module haar_lift_stage
    import wavelet_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic signed [W-1:0]                s_data,
`ifdef HAAR_DEADZONE_EN
    input  logic        [W-1:0]                thresh,
`endif
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic        [clog2_min1(CH)-1:0]   m_ch,
    output logic signed [W-1:0]                m_a,
    output logic signed [W:0]                  m_d
);

    localparam int unsigned CHW = clog2_min1(CH);
    localparam int unsigned DW  = detail_w(W);
    localparam logic [CHW-1:0] CH_LAST = CHW'(CH - 1);

    phase_e               phase_q;
    phase_e               phase_d;
    logic [CHW-1:0]       ch_q;
    logic [CHW-1:0]       ch_d;
    logic signed [W-1:0]  even_q [CH];
    logic signed [W-1:0]  even_sel;
    logic                 accept;
    logic                 load_even;
    logic                 load_out;
    logic                 valid_d;
    logic        [W-1:0]  thresh_core;
    logic signed [W-1:0]  a_c;
    logic signed [DW-1:0] d_c;

    // Output register is free when empty or draining this cycle
    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign even_sel = even_q[ch_q];

`ifdef HAAR_DEADZONE_EN
    assign thresh_core = thresh;
`else
    assign thresh_core = '0;
`endif

    haar_lift_core #(
        .W (W)
    ) u_core (
        .even   (even_sel),
        .odd    (s_data),
        .thresh (thresh_core),
        .a      (a_c),
        .d      (d_c)
    );

    // Next-state: channel counter, phase toggle on wrap, output valid handshake
    always_comb begin
        ch_d      = ch_q;
        phase_d   = phase_q;
        load_even = 1'b0;
        load_out  = 1'b0;
        valid_d   = m_valid;

        if (m_valid && m_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (ch_q == CH_LAST) begin
                ch_d    = '0;
                phase_d = (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
            end else begin
                ch_d = ch_q + CHW'(1);
            end

            case (phase_q)
                PH_EVEN: begin
                    load_even = 1'b1;
                end
                PH_ODD: begin
                    load_out = 1'b1;
                    valid_d  = 1'b1;
                end
                default: begin
                    load_even = 1'b0;
                end
            endcase
        end
    end

    // State, per-channel even store and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_EVEN;
            ch_q    <= '0;
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_a     <= '0;
            m_d     <= '0;
            for (int i = 0; i < int'(CH); i++) begin
                even_q[i] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            ch_q    <= ch_d;
            m_valid <= valid_d;
            if (load_even) begin
                even_q[ch_q] <= s_data;
            end
            if (load_out) begin
                m_ch <= ch_q;
                m_a  <= a_c;
                m_d  <= d_c;
            end
        end
    end

endmodule

// File: tb/tb_haar_lift_stage.sv
// Self-checking bench for haar_lift_stage (W=8, CH=2) with a pair scoreboard.
// Define HAAR_DEADZONE_EN to also exercise the dead-zone threshold.
module tb_haar_lift_stage;

    localparam int W  = 8;
    localparam int CH = 2;

    typedef struct {
        int ch;
        int a;
        int d;
    } pair_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] s_data = '0;
    logic [W-1:0]        thresh = '0;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic [0:0]          m_ch;
    logic signed [W-1:0] m_a;
    logic signed [W:0]   m_d;

    int    errors = 0;
    int    checks = 0;
    pair_t exp_q[$];
    int    even_m [CH];
    int    mdl_ch = 0;
    int    mdl_phase = 0;
    bit    lat_pend = 1'b0;
    bit    stream_chk = 1'b0;
    bit    bp_en = 1'b0;
    int    drops = 0;
    int    accepted = 0;
    int    sent = 0;

    haar_lift_stage #(
        .W  (W),
        .CH (CH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
`ifdef HAAR_DEADZONE_EN
        .thresh  (thresh),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ch    (m_ch),
        .m_a     (m_a),
        .m_d     (m_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: predict on accept, compare on output transfer (sampled at negedge)
    initial begin
        pair_t e;
        int    ev, od, dd, aa, th;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mdl_ch    = 0;
                mdl_phase = 0;
                lat_pend  = 1'b0;
                for (int i = 0; i < CH; i++) even_m[i] = 0;
            end else begin
                if (lat_pend) begin
                    check("latency_valid", int'(m_valid), 1);
                    lat_pend = 1'b0;
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pair", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pair_ch", int'(m_ch), e.ch);
                        check("pair_a", int'(m_a), e.a);
                        check("pair_d", int'(m_d), e.d);
                    end
                end
                if (stream_chk && m_ready && !s_ready) drops++;
                if (s_valid && s_ready) begin
                    accepted++;
                    if (mdl_phase == 0) begin
                        even_m[mdl_ch] = int'(s_data);
                    end else begin
                        ev = even_m[mdl_ch];
                        od = int'(s_data);
                        dd = od - ev;
                        aa = (ev + od) >>> 1;
                        th = int'(thresh);
`ifdef HAAR_DEADZONE_EN
                        if (th != 0 && ((dd < 0) ? -dd : dd) < th) dd = 0;
`else
                        if (th < 0) dd = 0;
`endif
                        e.ch = mdl_ch;
                        e.a  = aa;
                        e.d  = dd;
                        exp_q.push_back(e);
                        lat_pend = 1'b1;
                    end
                    if (mdl_ch == CH - 1) begin
                        mdl_ch    = 0;
                        mdl_phase = 1 - mdl_phase;
                    end else begin
                        mdl_ch++;
                    end
                end
            end
        end
    end

    // Optional random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_accept();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic send(input int x);
        s_valid = 1'b1;
        s_data  = W'(x);
        sent++;
        wait_accept();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_ch", int'(m_ch), 0);
        check("rst_m_a", int'(m_a), 0);
        check("rst_m_d", int'(m_d), 0);
        check("rst_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [0:0]          c_ch;
        logic signed [W-1:0] c_a;
        logic signed [W:0]   c_d;
        time                 t0;

        do_reset();

        // Basic pairs: ch0 (10,4) -> a=7 d=-6; ch1 (5,6) -> a=5 d=1
        send(10); send(5); send(4); send(6);
        drain();

        // Extremes: ch0 (-128,127) -> a=-1 d=255
        send(-128); send(0); send(127); send(0);
        drain();

        // Backpressure: hold a pair 5 cycles, then release with next odd pending
        m_ready = 1'b0;
        send(1); send(2); send(3);
        @(negedge clk);
        c_ch = m_ch; c_a = m_a; c_d = m_d;
        check("stall_valid", int'(m_valid), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = W'(4);
        sent++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_s_ready", int'(s_ready), 0);
            check("stall_m_valid", int'(m_valid), 1);
            check("stall_m_a", int'(m_a), int'(c_a));
            check("stall_m_d", int'(m_d), int'(c_d));
            check("stall_m_ch", int'(m_ch), int'(c_ch));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_accept();
        drain();

        // Full rate: one sample per cycle, s_ready never drops
        stream_chk = 1'b1;
        t0 = $time;
        for (int i = 0; i < 20; i++) send($urandom_range(0, 255) - 128);
        check("stream_cycles", int'(($time - t0) / 10), 20);
        stream_chk = 1'b0;
        drain();
        check("stream_drops", drops, 0);

        // Random traffic with random backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) send($urandom_range(0, 255) - 128);
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();

        // Reset mid-pair: stored 10 discarded; ch0 (3,5) -> a=4 d=2
        send(10);
        do_reset();
        send(3); send(0); send(5); send(1);
        drain();

`ifdef HAAR_DEADZONE_EN
        // Dead zone: ch0 (10,8) -> d zeroed, a=9; ch1 (10,4) -> a=7 d=-6; thresh=0 passes d
        thresh = W'(4);
        send(10); send(10); send(8); send(4);
        drain();
        thresh = '0;
        send(10); send(10); send(8); send(4);
        drain();
`endif

        check("accepted_count", accepted, sent);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
